// File: rtl/rbcp_reg_pkg.sv
// Shared constants for the RBCP register slave: register offsets within the
// 16-byte window, the number of control bytes and the default ID byte.
package rbcp_reg_pkg;

  localparam logic [3:0] OFS_CTRL0  = 4'h0;
  localparam logic [3:0] OFS_STATUS = 4'h8;
  localparam logic [3:0] OFS_EVT    = 4'h9;
  localparam logic [3:0] OFS_PULSE  = 4'hA;
  localparam logic [3:0] OFS_ID     = 4'hB;

  localparam int NUM_CTRL = 8;

  localparam logic [7:0] ID_CODE_DEF = 8'hD5;

endpackage

// File: rtl/rbcp_evt_latch.sv
// 8-bit sticky event latch, cleared by a read; an event arriving in the same
// cycle as the clear survives it.
module rbcp_evt_latch (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] evt_set,
  input  logic       rd_clr,
  output logic [7:0] evt_q
);

  logic [7:0] evt_reg;
  logic [7:0] evt_next;

  always_comb begin
    evt_next = (rd_clr ? 8'h00 : evt_reg) | evt_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_reg <= 8'h00;
    end else begin
      evt_reg <= evt_next;
    end
  end

  assign evt_q = evt_reg;

endmodule

// File: rtl/rbcp_reg_slave.sv
// SiTCP RBCP responder: decodes a 16-byte window and answers each accepted
// single-byte strobe with a one-cycle LOC_ACK one clock later.
module rbcp_reg_slave
  import rbcp_reg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [7:0]  ID_CODE   = ID_CODE_DEF,
  parameter logic [63:0] CTRL_RST  = 64'h0
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        LOC_ACT,
  input  logic [31:0] LOC_ADDR,
  input  logic [7:0]  LOC_WD,
  input  logic        LOC_WE,
  input  logic        LOC_RE,
  output logic        LOC_ACK,
  output logic [7:0]  LOC_RD,
  output logic [63:0] CTRL_REG,
  input  logic [7:0]  STATUS_IN,
  input  logic [7:0]  EVENT_IN,
  output logic [7:0]  PULSE_OUT
);

  logic       hit;
  logic       acc;
  logic       wr_stb;
  logic       rd_stb;
  logic [3:0] ofs;
  logic [7:0] evt_q;
  logic [7:0] rd_next;
  logic [7:0] rd_reg;
  logic [7:0] pulse_next;
  logic [7:0] pulse_reg;
  logic       ack_reg;

  assign ofs    = LOC_ADDR[3:0];
  assign hit    = (LOC_ADDR[31:4] == BASE_ADDR[31:4]);
  assign acc    = LOC_ACT & (LOC_WE | LOC_RE) & hit;
  // A combined write+read strobe is treated purely as a write.
  assign wr_stb = acc & LOC_WE;
  assign rd_stb = acc & ~LOC_WE & LOC_RE;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CTRL; gi++) begin : g_ctrl
      logic [7:0] byte_reg;

      always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
          byte_reg <= CTRL_RST[8*gi +: 8];
        end else if (wr_stb && ofs == (OFS_CTRL0 + 4'(gi))) begin
          byte_reg <= LOC_WD;
        end
      end

      assign CTRL_REG[8*gi +: 8] = byte_reg;
    end
  endgenerate

  rbcp_evt_latch u_evt (
    .clk     (CLK),
    .rst_n   (RSTn),
    .evt_set (EVENT_IN),
    .rd_clr  (rd_stb && ofs == OFS_EVT),
    .evt_q   (evt_q)
  );

  // Read data is zero unless a read was accepted, so LOC_RD idles at 0x00.
  always_comb begin
    rd_next = 8'h00;
    if (rd_stb) begin
      case (ofs)
        OFS_STATUS: rd_next = STATUS_IN;
        OFS_EVT:    rd_next = evt_q;
        OFS_ID:     rd_next = ID_CODE;
        default: begin
          if (!ofs[3]) begin
            rd_next = CTRL_REG[{ofs[2:0], 3'b000} +: 8];
          end
        end
      endcase
    end
  end

  always_comb begin
    pulse_next = 8'h00;
    if (wr_stb && ofs == OFS_PULSE) begin
      pulse_next = LOC_WD;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ack_reg   <= 1'b0;
      rd_reg    <= 8'h00;
      pulse_reg <= 8'h00;
    end else begin
      ack_reg   <= acc;
      rd_reg    <= rd_next;
      pulse_reg <= pulse_next;
    end
  end

  assign LOC_ACK   = ack_reg;
  assign LOC_RD    = rd_reg;
  assign PULSE_OUT = pulse_reg;

endmodule
